// File: rtl/spi_flash_prog_ctrl.sv
// SPI-NOR program/erase sequencer: WREN, then opcode/address/page data, with fixed busy-wait completion.
// Latency: first SPI byte 1 cycle after command capture (erase) or after the last page byte (program).
// Backpressure: cmd_ready only in IDLE, wr_ready only in FILL; each SPI byte is held until spi_ready.
module spi_flash_prog_ctrl #(
    parameter int PAGE_BYTES     = 256,
    parameter int CS_GAP_CYCLES  = 64,
    parameter int PP_WAIT_CYCLES = 81000,
    parameter int SE_WAIT_CYCLES = 10800000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [23:0] cmd_addr,
    input  logic [8:0]  cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  spi_data,
    output logic        spi_valid,
    input  logic        spi_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int AW = (PAGE_BYTES > 1) ? $clog2(PAGE_BYTES) : 1;

    // Terminal counts; a zero parameter still spends one cycle in its state.
    localparam logic [31:0] GAP_LAST = (CS_GAP_CYCLES  == 0) ? 32'd0 : 32'(CS_GAP_CYCLES - 1);
    localparam logic [31:0] PP_LAST  = (PP_WAIT_CYCLES == 0) ? 32'd0 : 32'(PP_WAIT_CYCLES - 1);
    localparam logic [31:0] SE_LAST  = (SE_WAIT_CYCLES == 0) ? 32'd0 : 32'(SE_WAIT_CYCLES - 1);
    localparam logic [9:0]  PAGE_MAX = 10'(PAGE_BYTES);

    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_SE   = 8'h20;
    localparam logic [7:0] OP_PP   = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_WREN, S_GAP, S_OPC, S_ADDR, S_DATA, S_GAP2, S_WAIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        op_q;
    logic [23:0] addr_q;
    logic [8:0]  len_q;
    logic [8:0]  idx_q, idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        vld_d;
    logic [7:0]  dat_d;

    logic [7:0]    page_buf [PAGE_BYTES];
    logic [7:0]    rd_dat;
    logic [AW-1:0] rd_addr;

    logic        cmd_fire, wr_fire, spi_fire;
    logic        len_ok, idx_last;
    logic [31:0] wait_last;

    assign cmd_fire  = cmd_valid && cmd_ready;
    assign wr_fire   = wr_valid && wr_ready;
    assign spi_fire  = spi_valid && spi_ready;
    assign idx_last  = (idx_q == len_q - 9'd1);
    assign wait_last = op_q ? PP_LAST : SE_LAST;

    // Program length must be 1..PAGE_BYTES and must not cross a 256-byte flash page.
    assign len_ok = (len_q != 9'd0)
                 && ({1'b0, len_q} <= PAGE_MAX)
                 && (({2'b00, addr_q[7:0]} + {1'b0, len_q}) <= 10'd256);

    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_FILL) && len_ok;
    assign busy      = (state_q != S_IDLE) && !done;

    // Prefetch the byte after the one about to be presented, so DATA streams without bubbles.
    assign rd_addr = (state_d == S_DATA) ? AW'(idx_d + 9'd1) : '0;

    // Capture the command on the accepting handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
        end else if (cmd_fire) begin
            op_q   <= cmd_op;
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
        end
    end

    // Page buffer: written during FILL, read one cycle ahead of the SPI data register.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            page_buf[idx_q[AW-1:0]] <= wr_data;
        end
        rd_dat <= page_buf[rd_addr];
    end

    // State, counters and the registered SPI byte interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            spi_valid <= 1'b0;
            spi_data  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            spi_valid <= vld_d;
            spi_data  <= dat_d;
        end
    end

    // Next state; the next SPI byte is loaded on the edge that accepts the current one.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vld_d   = spi_valid;
        dat_d   = spi_data;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    idx_d = '0;
                    if (cmd_op) begin
                        state_d = S_FILL;
                    end else begin
                        state_d = S_WREN;
                        vld_d   = 1'b1;
                        dat_d   = OP_WREN;
                    end
                end
            end
            S_FILL: begin
                if (!len_ok) begin
                    done    = 1'b1;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end else if (wr_valid) begin
                    if (idx_last) begin
                        idx_d   = '0;
                        state_d = S_WREN;
                        vld_d   = 1'b1;
                        dat_d   = OP_WREN;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_WREN: begin
                if (spi_fire) begin
                    state_d = S_GAP;
                    vld_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = S_OPC;
                    vld_d   = 1'b1;
                    dat_d   = op_q ? OP_PP : OP_SE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_OPC: begin
                if (spi_fire) begin
                    state_d = S_ADDR;
                    dat_d   = addr_q[23:16];
                    idx_d   = '0;
                end
            end
            S_ADDR: begin
                if (spi_fire) begin
                    if (idx_q == 9'd2) begin
                        idx_d = '0;
                        if (op_q) begin
                            state_d = S_DATA;
                            dat_d   = rd_dat;
                        end else begin
                            state_d = S_GAP2;
                            vld_d   = 1'b0;
                            cnt_d   = '0;
                        end
                    end else begin
                        dat_d = (idx_q == 9'd0) ? addr_q[15:8] : addr_q[7:0];
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_DATA: begin
                if (spi_fire) begin
                    if (idx_last) begin
                        state_d = S_GAP2;
                        vld_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        dat_d = rd_dat;
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            S_GAP2: begin
                if (cnt_q >= GAP_LAST) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q >= wait_last) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_flash_prog_ctrl.sv
// Testbench for spi_flash_prog_ctrl: randomized commands against a byte-list reference model.
// Expected SPI bytes and completions are queued at issue time and checked by a negedge monitor.
// spi_ready is randomly throttled, and held low for a long stretch in one scenario.
module tb_spi_flash_prog_ctrl;

    localparam int PAGE_BYTES = 256;
    localparam int CS_GAP     = 64;
    localparam int PP_WAIT    = 50;
    localparam int SE_WAIT    = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [8:0]  cmd_len = '0;
    logic [7:0]  wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  spi_data;
    logic        spi_valid;
    logic        spi_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        err;

    spi_flash_prog_ctrl #(
        .PAGE_BYTES    (PAGE_BYTES),
        .CS_GAP_CYCLES (CS_GAP),
        .PP_WAIT_CYCLES(PP_WAIT),
        .SE_WAIT_CYCLES(SE_WAIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_addr (cmd_addr),
        .cmd_len  (cmd_len),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .spi_data (spi_data),
        .spi_valid(spi_valid),
        .spi_ready(spi_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       last_frame;
        logic       last_cmd;
    } exp_t;

    typedef struct packed {
        logic err;
        logic op;
    } dexp_t;

    exp_t       exp_q[$];
    dexp_t      done_q[$];
    logic [7:0] pdata[$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit stuck_low = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Reference model: the byte list the flash should see for one command, and its completion.
    task automatic model_cmd(input bit op, input logic [23:0] a, input int len, output bit ok);
        ok = 1'b1;
        if (op && (len < 1 || len > PAGE_BYTES || (int'(a[7:0]) + len) > 256)) begin
            ok = 1'b0;
            done_q.push_back('{err: 1'b1, op: op});
            return;
        end
        exp_q.push_back('{b: 8'h06, last_frame: 1'b1, last_cmd: 1'b0});
        exp_q.push_back('{b: (op ? 8'h02 : 8'h20), last_frame: 1'b0, last_cmd: 1'b0});
        exp_q.push_back('{b: a[23:16], last_frame: 1'b0, last_cmd: 1'b0});
        exp_q.push_back('{b: a[15:8], last_frame: 1'b0, last_cmd: 1'b0});
        exp_q.push_back('{b: a[7:0], last_frame: !op, last_cmd: !op});
        if (op) begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back('{b: pdata[i], last_frame: (i == len - 1), last_cmd: (i == len - 1)});
            end
        end
        done_q.push_back('{err: 1'b0, op: op});
    endtask

    task automatic gen_data(input int len);
        pdata.delete();
        for (int i = 0; i < len; i++) pdata.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic send_cmd(input bit op, input logic [23:0] a, input logic [8:0] l);
        int n = 0;
        bit got = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
        while (!got && n < 5000) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("cmd_accepted", 32'(got), 32'd1);
    endtask

    task automatic feed_data(input int len, input bit stalls);
        int i = 0;
        int guard = 0;
        while (i < len && guard < 5000) begin
            @(posedge clk); #1;
            if (stalls && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = pdata[i];
                @(negedge clk);
                if (wr_ready) i++;
            end
            guard++;
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("page_bytes_taken", 32'(i), 32'(len));
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    // Rejected program: done+err the cycle after capture, then nothing on either data port.
    task automatic reject_checks();
        @(negedge clk);
        chk("reject_done", 32'(done), 32'd1);
        chk("reject_err", 32'(err), 32'd1);
        chk("reject_wr_ready", 32'(wr_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reject_no_wr_ready", 32'(wr_ready), 32'd0);
            chk("reject_no_spi", 32'(spi_valid), 32'd0);
        end
    endtask

    task automatic run_cmd(input bit op, input logic [23:0] a, input int len, input bit stalls);
        bit ok;
        int t;
        model_cmd(op, a, len, ok);
        t = done_cnt + 1;
        send_cmd(op, a, 9'(len));
        if (!ok) reject_checks();
        else if (op) feed_data(len, stalls);
        wait_done(t);
    endtask

    // Randomly throttled SPI master; stuck_low models a master that never takes a byte.
    initial begin
        forever begin
            @(posedge clk); #1;
            spi_ready = stuck_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: SPI byte order, hold-while-stalled, no gap inside a command, CS gap, completions.
    initial begin : mon
        int         gap_cnt;
        bit         gap_armed, need_vld, prev_stall;
        logic [7:0] prev_dat;
        exp_t       e;
        dexp_t      d;
        gap_cnt = 0; gap_armed = 1'b0; need_vld = 1'b0; prev_stall = 1'b0; prev_dat = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                gap_cnt = 0; gap_armed = 1'b0; need_vld = 1'b0; prev_stall = 1'b0;
            end else begin
                if (need_vld) chk("no_valid_drop", 32'(spi_valid), 32'd1);
                if (prev_stall) begin
                    chk("hold_valid", 32'(spi_valid), 32'd1);
                    chk("hold_data", 32'(spi_data), 32'(prev_dat));
                end
                need_vld = 1'b0;
                if (!spi_valid) gap_cnt++;
                if (spi_valid && spi_ready) begin
                    if (gap_armed) begin
                        chk("cs_gap", 32'(gap_cnt >= CS_GAP), 32'd1);
                        gap_armed = 1'b0;
                    end
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spi_unexpected: got %0h expected no byte", spi_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("spi_byte", 32'(spi_data), 32'(e.b));
                        need_vld = !e.last_frame;
                        if (e.last_frame) begin
                            gap_armed = 1'b1;
                            gap_cnt   = 0;
                        end
                        if (e.last_cmd) last_cyc = cyc;
                    end
                    acc_cnt++;
                end
                prev_stall = spi_valid && !spi_ready;
                prev_dat   = spi_data;
                if (done) begin
                    done_cnt++;
                    chk("busy_at_done", 32'(busy), 32'd0);
                    if (done_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL done_unexpected: got done expected none");
                    end else begin
                        d = done_q.pop_front();
                        chk("done_err", 32'(err), 32'(d.err));
                        if (!d.err) begin
                            chk("done_latency", 32'(cyc - last_cyc),
                                32'(CS_GAP + (d.op ? PP_WAIT : SE_WAIT) + 1));
                            chk("bytes_drained", 32'(exp_q.size()), 32'd0);
                        end
                    end
                end else if (err) begin
                    checks++; errors++;
                    $display("FAIL err_without_done: got err=1 expected 0");
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit          rop, ok;
        logic [23:0] ra;
        int          rlen, sel, base, n, t, done_at, cap_at, k;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_spi_valid", 32'(spi_valid), 32'd0);
        chk("rst_spi_data", 32'(spi_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sector erase
        run_cmd(1'b0, 24'h012000, 0, 1'b0);

        // Short program with wr_valid stalls
        pdata.delete();
        pdata.push_back(8'hA1); pdata.push_back(8'hB2);
        pdata.push_back(8'hC3); pdata.push_back(8'hD4);
        run_cmd(1'b1, 24'h000010, 4, 1'b1);

        // Page-crossing program is rejected
        gen_data(32);
        run_cmd(1'b1, 24'h0000F0, 32, 1'b1);

        // Full page
        gen_data(256);
        run_cmd(1'b1, 24'h000100, 256, 1'b0);

        // Reset while the sixth page byte is on the bus
        gen_data(16);
        model_cmd(1'b1, 24'h000200, 16, ok);
        base = acc_cnt;
        send_cmd(1'b1, 24'h000200, 9'd16);
        feed_data(16, 1'b0);
        n = 0;
        while (acc_cnt < base + 10 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        chk("reached_data5", 32'(acc_cnt >= base + 10), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_spi_valid", 32'(spi_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        done_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        run_cmd(1'b0, 24'h3F0000, 0, 1'b0);

        // cmd_valid held through DONE, then a stuck SPI master
        model_cmd(1'b0, 24'h0A0000, 0, ok);
        t = done_cnt + 1;
        send_cmd(1'b0, 24'h0A0000, 9'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_addr = 24'h0B1234; cmd_len = 9'd0;
        stuck_low = 1'b1;
        done_at = -1; cap_at = -1; k = 0;
        while (cap_at < 0 && k < 2000) begin
            @(negedge clk);
            k++;
            if (done) done_at = k;
            if (cmd_ready && cmd_valid) begin
                cap_at = k;
                model_cmd(1'b0, 24'h0B1234, 0, ok);
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("capture_after_done", 32'(cap_at - done_at), 32'd1);
        chk("first_done_seen", 32'(done_cnt >= t), 32'd1);
        repeat (150) @(negedge clk);
        chk("stuck_valid", 32'(spi_valid), 32'd1);
        chk("stuck_data", 32'(spi_data), 32'h06);
        chk("stuck_busy", 32'(busy), 32'd1);
        stuck_low = 1'b0;
        wait_done(t + 1);

        // Random mix of erases, valid programs and rejected programs
        for (int r = 0; r < 8; r++) begin
            rop  = 1'($urandom_range(0, 1));
            ra   = 24'($urandom);
            rlen = 0;
            if (rop) begin
                sel = $urandom_range(0, 5);
                case (sel)
                    0: rlen = 0;
                    1: rlen = 257 + $urandom_range(0, 254);
                    2: begin
                        ra[7:0] = 8'h80 | 8'($urandom_range(0, 127));
                        rlen    = $urandom_range(256, 257 - int'(ra[7:0]));
                    end
                    default: rlen = $urandom_range(256 - int'(ra[7:0]), 1);
                endcase
            end
            gen_data(rlen);
            run_cmd(rop, ra, rlen, 1'b1);
        end

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
